// File: rtl/io_pkg.sv
// Shared types and constants for the core's output-side UART transmit path.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int UART_DATA_BITS = 8;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Byte FIFO between the core's out port and the UART serialiser; head data is
// visible combinationally so the transmitter can load it on the pop edge.
module out_fifo
    import io_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 8,
    localparam int AW    = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB tells a wrapped (full) FIFO from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/io_tx_unit.sv
// Output I/O block: buffers bytes issued by the core and sends them as 8N1 UART
// frames, back-pressuring the core while the buffer is full.
module io_tx_unit
    import io_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        out_issued,
    input  logic [31:0] out_data,
    output logic        out_stall,
    output logic        txd,
    output logic        tx_busy,
    output logic [31:0] sent_bytes
);

    localparam int                    AW        = fifo_ptr_w(FIFO_DEPTH);
    localparam int                    BW        = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0]         BAUD_LAST = BW'(CLK_PER_BIT - 1);
    localparam logic [2:0]            LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic [AW:0]           FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    tx_state_e                 state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [AW:0]               fifo_count;
    logic                      baud_last;
    logic                      push;
    logic                      pop;
    logic [23:0]               unused_data_hi;

    assign unused_data_hi = out_data[31:8];

    // Stall comes from the FIFO pointers only, so there is no path from out_issued.
    assign out_stall = (fifo_count == FULL_CNT);
    assign push      = out_issued && !fifo_full;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (out_data[UART_DATA_BITS-1:0]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            sent_bytes <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state     <= START;
                        shift_reg <= fifo_head;
                        baud_cnt  <= '0;
                        txd       <= 1'b0;
                        tx_busy   <= 1'b1;
                    end else begin
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state     <= DATA;
                        bit_idx   <= '0;
                        baud_cnt  <= '0;
                        txd       <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            txd       <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        sent_bytes <= sent_bytes + 32'd1;
                        baud_cnt   <= '0;
                        // Back-to-back frames: reload straight into START, no idle bit.
                        if (!fifo_empty) begin
                            state     <= START;
                            shift_reg <= fifo_head;
                            txd       <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_tx_unit.sv
// Bench for io_tx_unit: directed frame table and corner sequences, plus random
// traffic checked every cycle against a queue-and-timer model of the UART link.
module tb_io_tx_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_issued = 1'b0;
    logic [31:0] out_data = '0;
    logic        out_stall;
    logic        txd;
    logic        tx_busy;
    logic [31:0] sent_bytes;

    always #5 clk = ~clk;

    io_tx_unit #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_issued (out_issued),
        .out_data   (out_data),
        .out_stall  (out_stall),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .sent_bytes (sent_bytes)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of accepted bytes and a timer through the current frame.
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    int          m_elapsed = 0;
    int unsigned m_sent = 0;
    logic [7:0]  m_cur = '0;
    bit          chk_en = 1'b0;

    task automatic model_step();
        bit acc;
        if (!rst_n) begin
            m_q.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
            m_sent    = 0;
            return;
        end
        acc = out_issued && (m_q.size() < DEPTH);
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == FRAME) begin
                m_sent++;
                m_active = 1'b0;
            end
        end
        if (!m_active && m_q.size() != 0) begin
            m_cur     = m_q.pop_front();
            m_elapsed = 0;
            m_active  = 1'b1;
        end
        if (acc) m_q.push_back(out_data[7:0]);
    endtask

    function automatic logic m_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_elapsed / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_txd",   32'(txd),       32'(m_txd()));
            check("model_stall", 32'(out_stall), 32'(m_q.size() == DEPTH));
            check("model_busy",  32'(tx_busy),   32'(m_active));
            check("model_sent",  sent_bytes,     m_sent);
        end
    end

    // Driver-side view of what the DUT accepted at each edge.
    int acc_cnt = 0;
    bit tb_acc = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt <= 0;
            tb_acc  <= 1'b0;
        end else begin
            tb_acc <= out_issued && !out_stall;
            if (out_issued && !out_stall) acc_cnt <= acc_cnt + 1;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [9:0]  bits;
    } frame_vec_t;

    frame_vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          exp_sent;
        int          base_acc;
        int          busy_run;
        bit          started;
        bit          saw_stall;
        bit          pend;
        bit          first_done;
        bit          done;
        logic        line[FRAME*6];
        logic [7:0]  dec;
        int          n;

        // Frame bits in send order (bit 0 first): start, d0..d7, stop.
        vecs[0] = '{32'h0000_00A5, 10'b1101001010};
        vecs[1] = '{32'hFFFF_FF3C, 10'b1001111000};
        vecs[2] = '{32'h0000_0000, 10'b1000000000};
        vecs[3] = '{32'h1234_56FF, 10'b1111111110};
        vecs[4] = '{32'h0000_0081, 10'b1100000010};

        // Reset held with the core issuing: nothing may be accepted.
        rst_n      = 1'b0;
        out_issued = 1'b1;
        out_data   = 32'h0000_0055;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_txd",   32'(txd),       32'd1);
        check("rst_stall", 32'(out_stall), 32'd0);
        check("rst_busy",  32'(tx_busy),   32'd0);
        check("rst_sent",  sent_bytes,     32'd0);
        rst_n      = 1'b1;
        out_issued = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("post_rst_txd",  32'(txd),     32'd1);
            check("post_rst_busy", 32'(tx_busy), 32'd0);
        end

        // Single frames from the table, one issue cycle each.
        exp_sent = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_data   = vecs[i].data;
            out_issued = 1'b1;
            @(negedge clk);
            out_issued = 1'b0;
            out_data   = $urandom;
            for (int k = 0; k < FRAME; k++) begin
                @(negedge clk);
                check("frame_txd",  32'(txd),     32'(vecs[i].bits[k / CPB]));
                check("frame_busy", 32'(tx_busy), 32'd1);
            end
            @(negedge clk);
            exp_sent++;
            check("frame_sent",     sent_bytes,     exp_sent);
            check("frame_idle_busy", 32'(tx_busy),  32'd0);
            check("frame_idle_txd",  32'(txd),      32'd1);
        end

        // Back-pressure: six bytes offered continuously, held while stalled.
        base_acc   = acc_cnt;
        busy_run   = 0;
        started    = 1'b0;
        saw_stall  = 1'b0;
        pend       = 1'b0;
        first_done = 1'b0;
        done       = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            out_issued = (acc_cnt - base_acc) < 6;
            out_data   = {24'hC0FFEE, 8'(acc_cnt - base_acc + 1)};
            @(negedge clk);
            if (out_stall) saw_stall = 1'b1;
            if (pend) begin
                check("full_pop_retry_acc", 32'(acc_cnt - base_acc), 32'd6);
                pend = 1'b0;
            end
            if (!first_done && sent_bytes == 32'(exp_sent + 1)) begin
                first_done = 1'b1;
                pend       = 1'b1;
                check("full_pop_no_acc", 32'(acc_cnt - base_acc), 32'd5);
                check("full_pop_stall",  32'(out_stall),          32'd0);
            end
            if (tx_busy) begin
                started = 1'b1;
                if (busy_run < FRAME * 6) line[busy_run] = txd;
                busy_run++;
            end else if (started) begin
                done = 1'b1;
            end
        end
        out_issued = 1'b0;
        check("bp_finished",  32'(done),      32'd1);
        check("bp_saw_stall", 32'(saw_stall), 32'd1);
        check("bp_busy_run",  busy_run,       FRAME * 6);
        exp_sent += 6;
        check("bp_sent", sent_bytes, exp_sent);
        for (int f = 0; f < 6; f++) begin
            check("bp_start_bit", 32'(line[FRAME*f + CPB/2]), 32'd0);
            for (int b = 0; b < 8; b++) dec[b] = line[FRAME*f + CPB*(b+1) + CPB/2];
            check("bp_byte", 32'(dec), 32'(f + 1));
            check("bp_stop_bit", 32'(line[FRAME*f + CPB*9 + CPB/2]), 32'd1);
        end

        // Random traffic; a stalled request is held until accepted.
        out_issued = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!(out_issued && !tb_acc)) begin
                out_issued = ($urandom_range(0, 99) < ((cyc < 1000) ? 15 : 40));
                out_data   = $urandom;
            end
            @(negedge clk);
        end
        out_issued = 1'b0;
        n = 0;
        while ((m_active || m_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rand_drained", 32'(m_active || m_q.size() != 0), 32'd0);
        @(negedge clk);
        check("rand_idle_busy", 32'(tx_busy), 32'd0);

        // Reset in the middle of data bit 3 of 0x5A with two bytes queued.
        @(negedge clk);
        out_data   = 32'h0000_005A;
        out_issued = 1'b1;
        @(negedge clk);
        out_data   = 32'h0000_0011;
        @(negedge clk);
        out_data   = 32'h0000_0022;
        @(negedge clk);
        out_issued = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_bit2", 32'(txd), 32'd0);
        repeat (4) @(negedge clk);
        check("mid_bit3", 32'(txd), 32'd1);
        check("mid_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_txd",   32'(txd),       32'd1);
        check("mid_rst_busy",  32'(tx_busy),   32'd0);
        check("mid_rst_stall", 32'(out_stall), 32'd0);
        check("mid_rst_sent",  sent_bytes,     32'd0);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            check("after_rst_txd",  32'(txd),     32'd1);
            check("after_rst_busy", 32'(tx_busy), 32'd0);
            check("after_rst_sent", sent_bytes,   32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_tx_unit.md
Name: io_tx_unit

Overview:
- Output-side I/O block sitting directly downstream of the pipelined core's out port.
- Consumes out_issued/out_data from the core's exec stage, buffers bytes in a small FIFO and serialises them on a UART TX line (8N1, LSB first).
- Back-pressures the core via out_stall, which the hazard unit turns into a pipeline stall.
- Also exposes a running count of bytes fully transmitted.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- out_issued  in  1  core requests emission of one byte this cycle.
- out_data  in  32  byte to send in [7:0]; [31:8] ignored.
- out_stall  out  1  FIFO full; core must hold and re-present the same byte.
- txd  out  1  UART serial line, idle high.
- tx_busy  out  1  high whenever the FSM is not in IDLE.
- sent_bytes  out  32  number of frames whose stop bit has completed; wraps modulo 2^32.

Behaviour:
- Reset (rst_n low at an edge):
  - txd=1, out_stall=0, tx_busy=0, sent_bytes=0.
  - FIFO emptied, FSM to IDLE, bit/baud counters cleared.
- Reset mid-frame:
  - txd returns high at that edge and the frame is truncated.
  - Buffered bytes are discarded; sent_bytes is not incremented.
- Push rule:
  - Accept iff out_issued=1 and out_stall=0 at the edge; out_data[7:0] is written at the tail.
  - out_stall = (count == FIFO_DEPTH), driven from registered state only; no combinational path from out_issued.
  - When full, no push occurs even if a pop happens in the same cycle. The core retries next cycle.
- Simultaneous push and pop when not full: both occur and count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty at an edge, pop head into an 8-bit shift register, go to START, reset baud counter. Else stay, with txd=1.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLK_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles. On the final cycle sent_bytes increments. If the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length: exactly 10*CLK_PER_BIT cycles.
- Latency: a byte pushed into an empty FIFO at edge t is popped at edge t+1; txd falls at edge t+1.
- txd, tx_busy and sent_bytes are registered outputs.
- Baud counter counts 0..CLK_PER_BIT-1 and wraps; bit index is 3 bits.

Decomposition:
- Package io_pkg:
  - tx_state_e enum (IDLE, START, DATA, STOP).
  - UART_DATA_BITS=8.
  - Width helper for the FIFO pointers ($clog2(FIFO_DEPTH)).
- Sub-module out_fifo: synchronous FIFO with push/pop/full/empty/count.
  - Pointers of $clog2(FIFO_DEPTH)+1 bits; full/empty are distinguished by the MSB.
  - Read data is valid combinationally at the head.

Test Plan (CLK_PER_BIT=4, FIFO_DEPTH=4):
- Reset: hold rst_n=0 for 3 edges with out_issued=1 -> txd=1, out_stall=0, tx_busy=0, sent_bytes=0, nothing transmitted after release until a new issue.
- Single byte: one-cycle out_issued with out_data=0x0000_00A5 -> txd from next edge is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 total); sent_bytes=1 on the final stop cycle; tx_busy drops afterwards.
- Upper bits ignored: out_data=0xFFFF_FF3C -> frame carries 0x3C (data bits 0,0,1,1,1,1,0,0).
- Back-pressure: out_issued held high for 6 bytes 0x01..0x06, core model holding data while out_stall=1 -> out_stall asserts once 4 bytes are buffered; all 6 bytes transmitted in order; frames contiguous (240 cycles, no idle high gap); sent_bytes=6; no byte duplicated or dropped.
- Push at full with simultaneous pop: FIFO full and STOP ends with the pop -> that cycle's issue is not accepted; accepted next cycle; order preserved.
- Reset mid-frame: rst_n low during DATA bit 3 of 0x5A with 2 bytes queued -> txd=1 at that edge; FIFO empty; sent_bytes=0; no further frames.
